gbc_lcd_pattern_tx: RTL and testbench

//  Drives the GBC LCD interface (DCLK, SPS, SPL, 6-bit pixel data) from a built-in pattern source.
//  It is the transmit end of the link that gbc_display_capture receives.

---
 rtl/gbc_lcd_pattern_tx.sv | 277 +++++++++++++++++++++++++++
 tb/tb_gbc_lcd_pattern_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gbc_lcd_pattern_tx.sv
// gbc_lcd_pattern_tx
// Pattern generator that drives a GBC-style LCD link (DCLK, SPS, SPL, 6-bit
// pixel data). It is the transmit counterpart of gbc_display_capture and serves
// as a stimulus source or as an on-board loopback when no console is attached.
//
// Timing model: the FSM state and counters always describe the *next* DCLK
// period to be emitted. On every rise tick the output registers are loaded
// with that period's SPS/SPL/data and the FSM advances to the period after it.
// The values therefore change together with the DCLK rising edge and stay
// stable across the falling edge, where the receiver samples them.
module gbc_lcd_pattern_tx #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int H_BLANK  = 40,
  parameter int V_BLANK  = 10,
  parameter int CLK_DIV  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_pattern,
  input  logic [5:0] i_solidColor,
  output logic       o_gbcDCLK,
  output logic       o_gbcSPS,
  output logic       o_gbcSPL,
  output logic [5:0] o_gbcPixelData,
  output logic       o_busy,
  output logic       o_frameDone
);

  // Periods per line and per vertical blanking interval.
  localparam int L_TOT      = 1 + H_PIXELS + H_BLANK;
  localparam int VB_PERIODS = V_BLANK * L_TOT;

  // Counter widths; each is at least one bit even for degenerate parameters.
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int X_W   = $clog2(((H_PIXELS > H_BLANK) ? H_PIXELS : H_BLANK) + 1);
  localparam int LN_W  = $clog2(V_LINES + 1);
  localparam int VB_W  = $clog2(VB_PERIODS + 2);

  // Terminal counts.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_PIXELS - 1);
  localparam logic [X_W-1:0]   HB_LAST  = X_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(V_LINES - 1);
  localparam logic [VB_W-1:0]  VB_LAST  = VB_W'((VB_PERIODS > 0) ? VB_PERIODS - 1 : 0);

  // S_FEND means "the next period lies beyond the frame": the end-of-frame
  // decision (restart or stop) is taken at the rise tick that would start it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK,
    S_FEND
  } state_t;

  // Registered state.
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             dclk;
  logic             sps;
  logic             spl;
  logic [5:0]       pix;
  logic             busy;
  logic             done;
  logic [X_W-1:0]   x_cnt;
  logic [LN_W-1:0]  line_cnt;
  logic [VB_W-1:0]  vb_cnt;
  logic [7:0]       frame_cnt;
  logic [1:0]       pat;
  logic [5:0]       color;

  // Next-state values.
  state_t           state_nx;
  logic [DIV_W-1:0] div_nx;
  logic             dclk_nx;
  logic             sps_nx;
  logic             spl_nx;
  logic [5:0]       pix_nx;
  logic             busy_nx;
  logic             done_nx;
  logic [X_W-1:0]   x_nx;
  logic [LN_W-1:0]  line_nx;
  logic [VB_W-1:0]  vb_nx;
  logic [7:0]       frame_nx;
  logic [1:0]       pat_nx;
  logic [5:0]       color_nx;

  // Helpers.
  logic       tick;
  logic       rise;
  state_t     eol_state;
  logic [5:0] x6;
  logic [5:0] y6;
  logic [5:0] pat_px;

  // Pixel value for the current (x, y) under the pattern latched for this frame.
  always_comb begin
    x6     = 6'(x_cnt);
    y6     = 6'(line_cnt);
    pat_px = 6'd0;
    unique case (pat)
      2'd0:    pat_px = color;
      2'd1:    pat_px = x6;
      2'd2:    pat_px = x6 ^ y6;
      default: pat_px = x6 + frame_cnt[5:0];
    endcase
  end

  // Divider, period sequencing and output staging.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_nx  = state;
    div_nx    = div_cnt;
    dclk_nx   = dclk;
    sps_nx    = sps;
    spl_nx    = spl;
    pix_nx    = pix;
    busy_nx   = busy;
    done_nx   = 1'b0;
    x_nx      = x_cnt;
    line_nx   = line_cnt;
    vb_nx     = vb_cnt;
    frame_nx  = frame_cnt;
    pat_nx    = pat;
    color_nx  = color;

    tick      = (div_cnt == DIV_LAST);
    rise      = tick && !dclk;
    eol_state = (line_cnt == LN_LAST) ? ((V_BLANK == 0) ? S_FEND : S_VBLANK) : S_SYNC;

    if (state == S_IDLE) begin
      // Divider parked at 0 so the first rise lands CLK_DIV cycles after start.
      div_nx  = '0;
      dclk_nx = 1'b0;
      if (i_enable) begin
        state_nx = S_SYNC;
        busy_nx  = 1'b1;
        pat_nx   = i_pattern;
        color_nx = i_solidColor;
        line_nx  = '0;
        x_nx     = '0;
        vb_nx    = '0;
      end
    end else begin
      div_nx = tick ? '0 : div_cnt + 1'b1;
      if (tick && dclk) begin
        dclk_nx = 1'b0;
      end else if (rise) begin
        dclk_nx = 1'b1;
        unique case (state)
          S_SYNC: begin
            sps_nx   = (line_cnt == '0);
            spl_nx   = 1'b1;
            pix_nx   = 6'd0;
            x_nx     = '0;
            state_nx = S_ACTIVE;
          end
          S_ACTIVE: begin
            sps_nx = 1'b0;
            spl_nx = 1'b0;
            pix_nx = pat_px;
            if (x_cnt == X_LAST) begin
              x_nx = '0;
              if (H_BLANK == 0) begin
                line_nx  = line_cnt + 1'b1;
                state_nx = eol_state;
              end else begin
                state_nx = S_HBLANK;
              end
            end else begin
              x_nx = x_cnt + 1'b1;
            end
          end
          S_HBLANK: begin
            sps_nx = 1'b0;
            spl_nx = 1'b0;
            pix_nx = 6'd0;
            if (x_cnt == HB_LAST) begin
              x_nx     = '0;
              line_nx  = line_cnt + 1'b1;
              state_nx = eol_state;
            end else begin
              x_nx = x_cnt + 1'b1;
            end
          end
          S_VBLANK: begin
            sps_nx = 1'b0;
            spl_nx = 1'b0;
            pix_nx = 6'd0;
            if (vb_cnt == VB_LAST) begin
              vb_nx    = '0;
              state_nx = S_FEND;
            end else begin
              vb_nx = vb_cnt + 1'b1;
            end
          end
          S_FEND: begin
            done_nx  = 1'b1;
            frame_nx = frame_cnt + 8'd1;
            line_nx  = '0;
            x_nx     = '0;
            vb_nx    = '0;
            if (i_enable) begin
              // Back-to-back frame: this rise already carries line 0's SYNC.
              pat_nx   = i_pattern;
              color_nx = i_solidColor;
              sps_nx   = 1'b1;
              spl_nx   = 1'b1;
              pix_nx   = 6'd0;
              state_nx = S_ACTIVE;
            end else begin
              // Suppress the rise and park with DCLK low.
              dclk_nx  = 1'b0;
              div_nx   = '0;
              sps_nx   = 1'b0;
              spl_nx   = 1'b0;
              pix_nx   = 6'd0;
              busy_nx  = 1'b0;
              state_nx = S_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State register; synchronous reset wins over every other event.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      dclk      <= 1'b0;
      sps       <= 1'b0;
      spl       <= 1'b0;
      pix       <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_cnt     <= '0;
      line_cnt  <= '0;
      vb_cnt    <= '0;
      frame_cnt <= 8'd0;
      pat       <= 2'd0;
      color     <= 6'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= state_nx;
      div_cnt   <= div_nx;
      dclk      <= dclk_nx;
      sps       <= sps_nx;
      spl       <= spl_nx;
      pix       <= pix_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      x_cnt     <= x_nx;
      line_cnt  <= line_nx;
      vb_cnt    <= vb_nx;
      frame_cnt <= frame_nx;
      pat       <= pat_nx;
      color     <= color_nx;
    end
  end

  assign o_gbcDCLK      = dclk;
  assign o_gbcSPS       = sps;
  assign o_gbcSPL       = spl;
  assign o_gbcPixelData = pix;
  assign o_busy         = busy;
  assign o_frameDone    = done;

endmodule

// File: tb/tb_gbc_lcd_pattern_tx.sv
// Directed bench for gbc_lcd_pattern_tx with a small geometry:
// CLK_DIV=2, H_PIXELS=4, V_LINES=3, H_BLANK=2, V_BLANK=1
// -> 7 DCLK periods per line, 28 per frame, 112 clk per frame.
module tb_gbc_lcd_pattern_tx;

  localparam int PER_LINE  = 7;
  localparam int PER_FRAME = 28;
  localparam int CLK_PER_P = 4;
  localparam int FRAME_CLK = PER_FRAME * CLK_PER_P;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] pattern;
  logic [5:0] solid;
  logic       dclk;
  logic       sps;
  logic       spl;
  logic [5:0] data;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] last_data [PER_FRAME];

  gbc_lcd_pattern_tx #(
    .H_PIXELS (4),
    .V_LINES  (3),
    .H_BLANK  (2),
    .V_BLANK  (1),
    .CLK_DIV  (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (enable),
    .i_pattern      (pattern),
    .i_solidColor   (solid),
    .o_gbcDCLK      (dclk),
    .o_gbcSPS       (sps),
    .o_gbcSPL       (spl),
    .o_gbcPixelData (data),
    .o_busy         (busy),
    .o_frameDone    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel for frame period p, from the frame layout and pattern rules.
  function automatic logic [5:0] exp_px(input int pat, input int k, input int p, input logic [5:0] col);
    int ln;
    int pos;
    int x;
    ln  = p / PER_LINE;
    pos = p % PER_LINE;
    x   = pos - 1;
    if (ln >= 3 || pos == 0 || pos > 4) return 6'd0;
    case (pat)
      0:       return col;
      1:       return 6'(x);
      2:       return 6'(x ^ ln);
      default: return 6'((x + k) % 64);
    endcase
  endfunction

  // Called right after the edge that carries the frame's first DCLK rise.
  // Samples each of the 112 clocks, returns after the edge that ends the frame.
  task automatic grab_frame(input int pat, input int k, input int drop_p,
                            input logic [5:0] col, input string name);
    logic [27:0] sps_v;
    logic [27:0] spl_v;
    int unstable;
    int dclk_bad;
    int done_hits;
    sps_v     = '0;
    spl_v     = '0;
    unstable  = 0;
    dclk_bad  = 0;
    done_hits = 0;
    for (int p = 0; p < PER_FRAME; p++) begin
      for (int c = 0; c < CLK_PER_P; c++) begin
        if (c == 0) begin
          sps_v[p]     = sps;
          spl_v[p]     = spl;
          last_data[p] = data;
        end else if ({sps, spl, data} !== {sps_v[p], spl_v[p], last_data[p]}) begin
          unstable++;
        end
        if (dclk !== ((c < 2) ? 1'b1 : 1'b0)) dclk_bad++;
        if (done && !(p == 0 && c == 0)) done_hits++;
        if (p == drop_p && c == 0) enable = 1'b0;
        step();
      end
    end
    check($sformatf("%s_sps", name), sps_v, 28'h0000001);
    check($sformatf("%s_spl", name), spl_v, 28'h0004081);
    for (int p = 0; p < PER_FRAME; p++)
      check($sformatf("%s_data_p%0d", name, p), last_data[p], exp_px(pat, k, p, col));
    check($sformatf("%s_stable", name), unstable, 0);
    check($sformatf("%s_dclk", name), dclk_bad, 0);
    check($sformatf("%s_done_early", name), done_hits, 0);
  endtask

  initial begin
    int hits;
    rst     = 1'b1;
    enable  = 1'b0;
    pattern = 2'd0;
    solid   = 6'd0;

    // Reset state and idle quiet period.
    repeat (5) step();
    check("rst_dclk", dclk, 0);
    check("rst_sps", sps, 0);
    check("rst_spl", spl, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst  = 1'b0;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (dclk || sps || spl || busy || done || data != 6'd0) hits++;
    end
    check("idle_quiet", hits, 0);

    // Start: x-ramp; first rise CLK_DIV clocks after the enable sample.
    pattern = 2'd1;
    enable  = 1'b1;
    step();
    check("start_busy", busy, 1);
    check("start_dclk_c0", dclk, 0);
    step();
    check("start_dclk_c1", dclk, 0);
    step();
    check("first_rise", dclk, 1);
    check("first_sps", sps, 1);
    pattern = 2'd2;  // must not affect the frame already started
    grab_frame(1, 0, -1, 6'd0, "f0");
    check("f0_done", done, 1);
    check("f0_busy", busy, 1);

    // x^y frame.
    pattern = 2'd3;
    grab_frame(2, 1, -1, 6'd0, "f1");
    check("f1_done", done, 1);

    // Scrolling ramp for frames 2..4.
    for (int k = 2; k <= 4; k++) begin
      grab_frame(3, k, -1, 6'd0, $sformatf("f%0d", k));
      check($sformatf("f%0d_done", k), done, 1);
    end

    // Run on to frame 254 and watch the counter wrap.
    repeat ((254 - 5) * FRAME_CLK) step();
    grab_frame(3, 254, -1, 6'd0, "f254");
    check("wrap_x0", last_data[1], 62);
    check("wrap_x1", last_data[2], 63);
    grab_frame(3, 255, -1, 6'd0, "f255");

    // Frame 256 (counter back to 0); enable dropped at line 1.
    grab_frame(3, 0, PER_LINE, 6'd0, "f256");
    check("f256_x0", last_data[1], 0);
    check("stop_done", done, 1);
    check("stop_busy", busy, 0);
    check("stop_dclk", dclk, 0);
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (dclk || spl || sps || busy) hits++;
    end
    check("stop_quiet", hits, 0);

    // Reset in the middle of an active period, then clean restart.
    pattern = 2'd1;
    enable  = 1'b1;
    repeat (3) step();
    check("rs_first_sps", sps, 1);
    repeat (8) step();
    check("rs_pre_data", data, 1);
    rst = 1'b1;
    step();
    check("rs_outputs", {dclk, sps, spl, data, busy, done}, 0);
    rst     = 1'b0;
    pattern = 2'd0;
    solid   = 6'h2A;
    step();
    check("rs_busy", busy, 1);
    solid = 6'h15;  // latched value 0x2A must remain in use
    step();
    check("rs_dclk_c1", dclk, 0);
    step();
    check("rs_rise", dclk, 1);
    check("rs_sps", sps, 1);
    grab_frame(0, 0, 0, 6'h2A, "rs");
    check("rs_end_done", done, 1);
    check("rs_end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
